// File: rtl/imem_loader.sv
// imem_loader: writable 2^AW x IW instruction memory for the 9-bit CPU.
// Program words arrive over a valid/ready stream and are written from address 0
// upward. The remaining locations are then back-filled with FILL_WORD. The CPU is
// held in halt until the whole memory image is consistent.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   ld_start          request a new load (honored in IDLE or RUN only)
//   ld_valid/ld_data  program word stream; ld_last marks the final word
//   ld_ready          word accepted on this cycle's edge when ld_valid is high
//   PC / inst         combinational fetch port
//   cpu_halt          CPU must not advance while high
//   ld_done           one-cycle pulse when load and back-fill are complete
//   ld_count          words accepted in the current or most recent load
//   ld_err            sticky: final address filled without ld_last
//
// state | meaning
// IDLE  | after reset; CPU halted, memory readable, waiting for ld_start
// LOAD  | accepting program words, ld_ready high
// FILL  | writing FILL_WORD to every address after the last program word
// DONE  | single cycle announcing completion (ld_done)
// RUN   | CPU released; ld_start begins a reload
module imem_loader #(
  parameter int AW = 8,
  parameter int IW = 9,
  parameter logic [IW-1:0] FILL_WORD = 9'b111_111_111
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [IW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic [AW-1:0] PC,
  output logic [IW-1:0] inst,
  output logic          cpu_halt,
  output logic          ld_done,
  output logic [AW:0]   ld_count,
  output logic          ld_err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    FILL = 3'd2,
    DONE = 3'd3,
    RUN  = 3'd4
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  state_t        state;
  logic [AW-1:0] addr;
  logic [IW-1:0] mem [0:(2**AW)-1];
  logic          accept;

  // ld_ready is a register, so there is no path from ld_valid back to ld_ready.
  assign accept = (state == LOAD) && ld_valid && ld_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      addr     <= '0;
      ld_count <= '0;
      ld_err   <= 1'b0;
      ld_ready <= 1'b0;
      cpu_halt <= 1'b1;
      ld_done  <= 1'b0;
    end else begin
      ld_done <= 1'b0;
      unique case (state)
        IDLE, RUN: begin
          if (ld_start) begin
            state    <= LOAD;
            addr     <= '0;
            ld_count <= '0;
            ld_err   <= 1'b0;
            ld_ready <= 1'b1;
            cpu_halt <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            ld_count <= ld_count + 1'b1;
            if (addr == LAST_ADDR && !ld_last) ld_err <= 1'b1;
            if (ld_last || addr == LAST_ADDR) begin
              ld_ready <= 1'b0;
              if (addr == LAST_ADDR) begin
                // Memory is full: no back-fill, and the address never wraps.
                state   <= DONE;
                ld_done <= 1'b1;
              end else begin
                state <= FILL;
                addr  <= addr + 1'b1;
              end
            end else begin
              addr <= addr + 1'b1;
            end
          end
        end
        FILL: begin
          if (addr == LAST_ADDR) begin
            state   <= DONE;
            ld_done <= 1'b1;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        DONE: begin
          state    <= RUN;
          cpu_halt <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM has no reset so contents survive a reset; writes are gated by state,
  // which reset forces to IDLE.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[addr] <= ld_data;
    end else if (state == FILL) begin
      mem[addr] <= FILL_WORD;
    end
  end

  // While the image is being rewritten the CPU sees only the default word.
  always_comb begin
    inst = FILL_WORD;
    if (state == IDLE || state == RUN) inst = mem[PC];
  end

endmodule
